// File: rtl/vend_pkg.sv
// Shared types and encodings for the vending controller and its greedy change selector.
package vend_pkg;

    localparam int CREDIT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_VEND,
        S_COIN_ON,
        S_COIN_GAP,
        S_CLEAR
    } state_t;

    localparam logic [CREDIT_W-1:0] COIN50_VAL = 8'd50;
    localparam logic [CREDIT_W-1:0] COIN20_VAL = 8'd20;
    localparam logic [CREDIT_W-1:0] COIN10_VAL = 8'd10;
    localparam logic [CREDIT_W-1:0] COIN5_VAL  = 8'd5;

    localparam logic [3:0] COIN50_OH = 4'b1000;
    localparam logic [3:0] COIN20_OH = 4'b0100;
    localparam logic [3:0] COIN10_OH = 4'b0010;
    localparam logic [3:0] COIN5_OH  = 4'b0001;

    localparam logic [3:0] ITEM0_OH = 4'b0001;
    localparam logic [3:0] ITEM1_OH = 4'b0010;
    localparam logic [3:0] ITEM2_OH = 4'b0100;
    localparam logic [3:0] ITEM3_OH = 4'b1000;

    function automatic logic [3:0] item_onehot(input logic [1:0] item);
        case (item)
            2'd0:    return ITEM0_OH;
            2'd1:    return ITEM1_OH;
            2'd2:    return ITEM2_OH;
            default: return ITEM3_OH;
        endcase
    endfunction

endpackage

// File: rtl/coin_pick.sv
// Combinational greedy change selector: largest of 50/20/10/5 not exceeding the remainder.
module coin_pick
    import vend_pkg::*;
(
    input  logic [CREDIT_W-1:0] remainder,
    output logic [3:0]          coin,
    output logic [CREDIT_W-1:0] value,
    output logic                none
);

    always_comb begin
        coin  = 4'b0000;
        value = '0;
        none  = 1'b0;
        if (remainder >= COIN50_VAL) begin
            coin  = COIN50_OH;
            value = COIN50_VAL;
        end else if (remainder >= COIN20_VAL) begin
            coin  = COIN20_OH;
            value = COIN20_VAL;
        end else if (remainder >= COIN10_VAL) begin
            coin  = COIN10_OH;
            value = COIN10_VAL;
        end else if (remainder >= COIN5_VAL) begin
            coin  = COIN5_OH;
            value = COIN5_VAL;
        end else begin
            none  = 1'b1;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: checks funds, pulses dispense, pays change coin by coin, then clears credit.
// Defining VEND_CTRL_TIMEOUT_EN builds an idle auto-refund counter.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE0      = 25,
    parameter int PRICE1      = 40,
    parameter int PRICE2      = 55,
    parameter int PRICE3      = 75,
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CREDIT_W-1:0] credit,
    input  logic [1:0]          sel,
    input  logic                buy,
    input  logic                cancel,
    output logic                busy,
    output logic [3:0]          vend_out,
    output logic                vend_valid,
    output logic [3:0]          coin_out,
    output logic                short_funds,
    output logic                credit_clr,
    output logic [CREDIT_W-1:0] change_left
);

    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    if (PULSE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("vend_ctrl: PULSE_CYC and TIMEOUT_CYC must be >= 1");
    end

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] item);
        case (item)
            2'd0:    return CREDIT_W'(PRICE0);
            2'd1:    return CREDIT_W'(PRICE1);
            2'd2:    return CREDIT_W'(PRICE2);
            default: return CREDIT_W'(PRICE3);
        endcase
    endfunction

    state_t              state, state_next;
    logic [1:0]          sel_q;
    logic [CREDIT_W-1:0] price_q, rem_q, rem_next, coin_val_q;
    logic [PW-1:0]       pulse_cnt;
    logic                pulse_last, funds_ok, refund_req, timeout;
    logic [3:0]          pick_coin;
    logic [CREDIT_W-1:0] pick_value;
    logic                pick_none;
    logic                busy_d, vend_valid_d, short_d, clr_d;
    logic [3:0]          vend_d, coin_d;

    assign pulse_last  = (pulse_cnt == PW'(PULSE_CYC - 1));
    assign funds_ok    = (credit >= price_q);
    assign refund_req  = (cancel || timeout) && (credit != '0);
    assign change_left = rem_q;

    // The selector looks at the remainder as it will be next cycle, so a coin can be
    // registered on the same edge that enters COIN_ON.
    coin_pick u_coin_pick (
        .remainder (rem_next),
        .coin      (pick_coin),
        .value     (pick_value),
        .none      (pick_none)
    );

`ifdef VEND_CTRL_TIMEOUT_EN
    logic [15:0]         idle_cnt;
    logic [CREDIT_W-1:0] credit_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt    <= '0;
            credit_prev <= '0;
        end else begin
            credit_prev <= credit;
            if (state != S_IDLE || buy || cancel || credit == '0 ||
                credit != credit_prev || timeout) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
        end
    end

    assign timeout = (state == S_IDLE) && (idle_cnt == 16'(TIMEOUT_CYC));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sel_q       <= '0;
            price_q     <= '0;
            rem_q       <= '0;
            coin_val_q  <= '0;
            pulse_cnt   <= '0;
            busy        <= 1'b0;
            vend_out    <= 4'b0000;
            vend_valid  <= 1'b0;
            coin_out    <= 4'b0000;
            short_funds <= 1'b0;
            credit_clr  <= 1'b0;
        end else begin
            state       <= state_next;
            rem_q       <= (state_next == S_CLEAR) ? '0 : rem_next;
            pulse_cnt   <= (state == S_COIN_ON && !pulse_last) ? pulse_cnt + PW'(1) : '0;
            if (state == S_IDLE && buy) begin
                sel_q   <= sel;
                price_q <= price_of(sel);
            end
            if (state_next == S_COIN_ON && state != S_COIN_ON) begin
                coin_val_q <= pick_value;
            end
            busy        <= busy_d;
            vend_out    <= vend_d;
            vend_valid  <= vend_valid_d;
            coin_out    <= coin_d;
            short_funds <= short_d;
            credit_clr  <= clr_d;
        end
    end

    always_comb begin
        state_next = state;
        rem_next   = rem_q;
        case (state)
            S_IDLE: begin
                if (buy) begin
                    state_next = S_CHECK;
                end else if (refund_req) begin
                    state_next = S_COIN_ON;
                    rem_next   = credit;
                end
            end
            S_CHECK: begin
                if (funds_ok) begin
                    state_next = S_VEND;
                    rem_next   = credit - price_q;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_VEND:     state_next = pick_none ? S_CLEAR : S_COIN_ON;
            S_COIN_ON: begin
                if (pulse_last) begin
                    state_next = S_COIN_GAP;
                    rem_next   = rem_q - coin_val_q;
                end
            end
            S_COIN_GAP: state_next = pick_none ? S_CLEAR : S_COIN_ON;
            S_CLEAR:    state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d       = (state_next != S_IDLE);
        vend_valid_d = (state_next == S_VEND);
        vend_d       = vend_valid_d ? item_onehot(sel_q) : 4'b0000;
        coin_d       = (state_next == S_COIN_ON) ? pick_coin : 4'b0000;
        short_d      = (state == S_CHECK) && !funds_ok;
        clr_d        = (state_next == S_CLEAR);
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: expected dispense/coin/clear events are queued as stimulus is driven.
module tb_vend_ctrl;

    localparam int EV_NONE  = 0;
    localparam int EV_VEND  = 1;
    localparam int EV_SHORT = 2;
    localparam int EV_COIN  = 3;
    localparam int EV_CLR   = 4;
    localparam int PULSE    = 4;

    typedef struct {
        int kind;
        int value;
        int cycle;
        int len;
        int rem;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] credit;
    logic [1:0] sel;
    logic       buy, cancel;
    logic       busy, vend_valid, short_funds, credit_clr;
    logic [3:0] vend_out, coin_out;
    logic [7:0] change_left;

    ev_t sb_q[$];
    int  price_tab[4] = '{25, 40, 55, 75};
    int  tests_run = 0;
    int  tests_failed = 0;
    int  cyc = 0;
    int  coin_len = 0, coin_val = 0, coin_start = 0, coin_rem = 0;
    int  coin_count = 0, clr_count = 0, last_coin_start = 0;

    vend_ctrl #(.TIMEOUT_CYC(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .credit      (credit),
        .sel         (sel),
        .buy         (buy),
        .cancel      (cancel),
        .busy        (busy),
        .vend_out    (vend_out),
        .vend_valid  (vend_valid),
        .coin_out    (coin_out),
        .short_funds (short_funds),
        .credit_clr  (credit_clr),
        .change_left (change_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic pushEvent(input int kind, input int value, input int at, input int len, input int rem);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        e.cycle = at;
        e.len   = len;
        e.rem   = rem;
        sb_q.push_back(e);
    endtask

    // Greedy change model: each coin is PULSE cycles high plus one gap cycle, then the clear.
    task automatic pushChange(input int t0, input int change);
        int t, r, v, oh;
        t = t0;
        r = change;
        while (r >= 5) begin
            if (r >= 50)      begin v = 50; oh = 8; end
            else if (r >= 20) begin v = 20; oh = 4; end
            else if (r >= 10) begin v = 10; oh = 2; end
            else              begin v = 5;  oh = 1; end
            pushEvent(EV_COIN, oh, t, PULSE, r);
            r = r - v;
            t = t + PULSE + 1;
        end
        pushEvent(EV_CLR, 0, t, 1, 0);
    endtask

    task automatic scoreEvent(input int kind, input int value, input int at, input int len, input int rem);
        ev_t e;
        if (sb_q.size() == 0) begin
            checkOutput("unexpected_event_kind", kind, EV_NONE);
            return;
        end
        e = sb_q.pop_front();
        checkOutput($sformatf("ev%0d_kind", e.kind), kind, e.kind);
        checkOutput($sformatf("ev%0d_value", e.kind), value, e.value);
        if (e.cycle >= 0) checkOutput($sformatf("ev%0d_cycle", e.kind), at, e.cycle);
        checkOutput($sformatf("ev%0d_len", e.kind), len, e.len);
        checkOutput($sformatf("ev%0d_change_left", e.kind), rem, e.rem);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            coin_len = 0;
        end else begin
            if (vend_valid)  scoreEvent(EV_VEND, int'(vend_out), cyc, 1, int'(change_left));
            if (short_funds) scoreEvent(EV_SHORT, 0, cyc, 1, int'(change_left));
            if (credit_clr) begin
                clr_count++;
                scoreEvent(EV_CLR, 0, cyc, 1, int'(change_left));
            end
            if (coin_len != 0 && int'(coin_out) != coin_val) begin
                scoreEvent(EV_COIN, coin_val, coin_start, coin_len, coin_rem);
                coin_len = 0;
            end
            if (coin_out != 4'b0000) begin
                if (coin_len == 0) begin
                    coin_val        = int'(coin_out);
                    coin_start      = cyc;
                    coin_rem        = int'(change_left);
                    last_coin_start = cyc;
                    coin_count++;
                end
                coin_len++;
            end
        end
    end

    task automatic applyStimulus(input int cr, input int s, input bit b, input bit cn,
                                 input bit expect_effect, output int c);
        int change;
        @(negedge clk);
        credit = 8'(cr);
        sel    = 2'(s);
        buy    = b;
        cancel = cn;
        c      = cyc;
        if (expect_effect) begin
            if (b) begin
                if (cr < price_tab[s]) begin
                    pushEvent(EV_SHORT, 0, c + 2, 1, 0);
                end else begin
                    change = cr - price_tab[s];
                    pushEvent(EV_VEND, 1 << s, c + 2, 1, change);
                    pushChange(c + 3, change);
                end
            end else if (cn && cr != 0) begin
                pushChange(c + 1, cr);
            end
        end
        @(negedge clk);
        buy    = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, int'(busy == 1'b0 && sb_q.size() == 0), 1);
        sb_q.delete();
        credit = 8'd0;
        @(negedge clk);
    endtask

    initial begin
        int c, c2, clr_before, coin_before;
        rst    = 1'b1;
        credit = 8'd0;
        sel    = 2'd0;
        buy    = 1'b0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_vend_valid", int'(vend_valid), 0);
        checkOutput("reset_vend_out", int'(vend_out), 0);
        checkOutput("reset_coin_out", int'(coin_out), 0);
        checkOutput("reset_short_funds", int'(short_funds), 0);
        checkOutput("reset_credit_clr", int'(credit_clr), 0);
        checkOutput("reset_change_left", int'(change_left), 0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(100, 1, 1'b1, 1'b0, 1'b1, c);
        checkOutput("check_busy", int'(busy), 1);
        waitIdle("vend_change60");

        applyStimulus(20, 0, 1'b1, 1'b0, 1'b1, c);
        repeat (2) @(negedge clk);
        checkOutput("short_at_buy3_cycle", cyc - c, 3);
        checkOutput("short_busy_low", int'(busy), 0);
        waitIdle("short_funds");

        applyStimulus(35, 0, 1'b0, 1'b1, 1'b1, c);
        repeat (3) @(negedge clk);
        applyStimulus(35, 3, 1'b1, 1'b0, 1'b0, c2);
        applyStimulus(35, 0, 1'b0, 1'b1, 1'b0, c2);
        waitIdle("cancel35");

        applyStimulus(75, 3, 1'b1, 1'b0, 1'b1, c);
        waitIdle("exact75");

        applyStimulus(27, 0, 1'b1, 1'b0, 1'b1, c);
        waitIdle("forfeit2");

        applyStimulus(60, 2, 1'b1, 1'b1, 1'b1, c);
        waitIdle("buy_and_cancel");

        applyStimulus(0, 1, 1'b0, 1'b1, 1'b1, c);
        repeat (3) @(negedge clk);
        checkOutput("cancel_zero_busy", int'(busy), 0);
        checkOutput("cancel_zero_queue", sb_q.size(), 0);

        applyStimulus(100, 0, 1'b1, 1'b0, 1'b1, c);
        repeat (8) @(negedge clk);
        checkOutput("second_coin_before_rst", int'(coin_out), 4);
        rst = 1'b1;
        #1;
        checkOutput("rst_coin_out", int'(coin_out), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_change_left", int'(change_left), 0);
        checkOutput("rst_credit_clr", int'(credit_clr), 0);
        sb_q.delete();
        clr_before = clr_count;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        credit = 8'd0;
        repeat (10) @(negedge clk);
        checkOutput("rst_no_clr", clr_count - clr_before, 0);
        checkOutput("rst_idle", int'(busy), 0);
        applyStimulus(50, 1, 1'b1, 1'b0, 1'b1, c);
        waitIdle("after_reset");

`ifdef VEND_CTRL_TIMEOUT_EN
        @(negedge clk);
        credit = 8'd10;
        c      = cyc;
        pushEvent(EV_COIN, 2, -1, PULSE, 10);
        pushEvent(EV_CLR, 0, -1, 1, 0);
        waitIdle("timeout_refund");
        checkOutput("timeout_not_early", int'(last_coin_start >= c + 15), 1);
        checkOutput("timeout_not_late", int'(last_coin_start <= c + 40), 1);
`else
        coin_before = coin_count;
        @(negedge clk);
        credit = 8'd10;
        repeat (100) @(negedge clk);
        checkOutput("no_auto_refund_coins", coin_count - coin_before, 0);
        checkOutput("no_auto_refund_busy", int'(busy), 0);
        credit = 8'd0;
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Downstream stage of the coin-acceptor block.
- Consumes the accumulated credit value and the customer buy/cancel requests.
- Decides whether to vend, pulses the selected item's dispense output, pays change coin by coin (greedy 50/20/10/5), then requests a credit clear from the acceptor.
- Single clock domain; sits between the acceptor and the dispenser/coin-hopper drivers.

Parameters:
- PRICE0, 25, price of item 0 in credit units.
- PRICE1, 40, price of item 1.
- PRICE2, 55, price of item 2.
- PRICE3, 75, price of item 3.
- PULSE_CYC, 4, cycles each change-coin pulse is held high (>=1).
- TIMEOUT_CYC, 1000, idle cycles before auto-refund (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high; one clock, no other clocks.
- credit  in  8  accumulated credit from the acceptor, unsigned; stable while busy.
- sel  in  2  item select; sampled together with buy.
- buy  in  1  single-cycle synchronous purchase strobe.
- cancel  in  1  single-cycle synchronous refund strobe.
- busy  out  1  high in every state except IDLE.
- vend_out  out  4  one-hot item dispense; valid only while vend_valid is high.
- vend_valid  out  1  one-cycle dispense pulse.
- coin_out  out  4  one-hot change coin: [3]=50, [2]=20, [1]=10, [0]=5.
- short_funds  out  1  one-cycle pulse when credit < price.
- credit_clr  out  1  one-cycle request for the acceptor to zero its credit.
- change_left  out  8  remaining change still to pay.

Behaviour:
- Reset values: state IDLE; all outputs 0; internal remainder and latched price 0.
- All outputs are registered.
- States: IDLE, CHECK, VEND, COIN_ON, COIN_GAP, CLEAR.
- IDLE + buy at cycle N:
  - Latch sel and its PRICEx; go to CHECK at N+1.
- CHECK, credit >= price:
  - remainder = credit - price (8-bit, no underflow possible).
  - Go to VEND; vend_valid=1 and vend_out = one-hot(sel) during cycle N+2.
- CHECK, credit < price:
  - short_funds=1 for one cycle; return to IDLE.
  - Credit is untouched; credit_clr is not pulsed.
- IDLE + cancel with credit != 0:
  - remainder = credit; go to COIN_ON (skip CHECK/VEND).
  - cancel with credit == 0 is ignored.
- buy and cancel in the same cycle: buy wins.
- buy/cancel while busy are ignored; they are not queued.
- VEND -> COIN_ON if remainder >= 5, else -> CLEAR.
- COIN_ON:
  - Coin = largest of 50/20/10/5 that is <= remainder.
  - coin_out holds that coin for exactly PULSE_CYC cycles.
  - On exit, remainder -= coin value; go to COIN_GAP.
- COIN_GAP:
  - coin_out=0 for exactly 1 cycle.
  - Then -> COIN_ON if remainder >= 5, else -> CLEAR.
- Remainder of 1..4 (credit not a multiple of 5): forfeited; remainder forced to 0 on entering CLEAR.
- CLEAR: credit_clr=1 for one cycle, then IDLE.
- change_left mirrors the remainder register at every cycle; it is 0 in IDLE.
- Exact payment: VEND -> CLEAR; no coin pulses.
- Reset mid-operation (any state):
  - Outputs drop to 0 immediately (asynchronous); state becomes IDLE.
  - Unpaid change is lost; credit_clr is not asserted.
- credit is read only in IDLE/CHECK; changes to it after CHECK are ignored.

Optional Feature:
- Macro: VEND_CTRL_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter runs while in IDLE with credit != 0 and no buy/cancel.
  - It clears on any buy, cancel, or change of credit value.
  - On reaching TIMEOUT_CYC it behaves exactly as a cancel (refund path).
- Not defined: no counter is built; credit is held indefinitely in IDLE.

Decomposition:
- Package vend_pkg:
  - state enum.
  - Coin value constants (50, 20, 10, 5) and their one-hot coin_out encodings.
  - Item one-hot encodings.
  - Credit width constant (8).
- Sub-module coin_pick: combinational greedy selector.
  - Input: remainder[7:0].
  - Outputs: coin one-hot[3:0], coin value[7:0], none flag (remainder < 5).
  - Instantiated once by vend_ctrl.

Test Plan:
- credit=100, sel=1, buy -> vend_out=0010 for 1 cycle at buy+2. Change 60 paid as coin_out=1000 (4 cycles), gap, 0010 (4 cycles), gap. Then credit_clr pulse, busy=0.
- credit=20, sel=0, buy -> short_funds pulse at buy+2, no vend, no coins, no credit_clr, busy low again at buy+3.
- credit=35, cancel -> no vend; coins 0100, 0010, 0001, each 4 cycles with 1-cycle gaps; change_left steps 35->15->5->0; credit_clr.
- credit=75, sel=3, buy -> vend_out=1000, no coin pulses, credit_clr the cycle after VEND.
- credit=100, sel=0, buy; assert rst during the second COIN_ON -> coin_out=0 immediately, busy=0, no credit_clr; a fresh buy after release works normally. Also: buy+cancel in the same cycle -> vend path is taken.
- With VEND_CTRL_TIMEOUT_EN and TIMEOUT_CYC=20: credit=10 held idle -> refund coin 0010 starts after 20 idle cycles. Without the macro: no coins after 100 cycles.
